// File: rtl/cpu_defs.sv
// Shared definitions for the CPU front end: opcode constants, the PCSrc
// encodings driven by control_unit, the fetch FSM state type and the
// instruction-word field positions.
package cpu_defs;

  // Instruction-word field positions.
  localparam int OP_MSB   = 15;
  localparam int FLAG_BIT = 10;

  // Opcode constants (OPCODE = IR[15:11]).
  localparam logic [4:0] OP_APUT = 5'b00000;
  localparam logic [4:0] OP_SPUT = 5'b00001;
  localparam logic [4:0] OP_BKRA = 5'b10110;

  // PCSrc encodings from control_unit.
  localparam logic [2:0] PCSRC_INC      = 3'b000;  // PC+1
  localparam logic [2:0] PCSRC_SHELLEY  = 3'b001;  // register-indirect
  localparam logic [2:0] PCSRC_IMM      = 3'b010;  // page-absolute immediate
  localparam logic [2:0] PCSRC_RA       = 3'b011;  // return
  localparam logic [2:0] PCSRC_MARY     = 3'b100;  // accumulator-indirect
  localparam logic [2:0] PCSRC_REL      = 3'b101;  // PC-relative by Mary
  localparam logic [2:0] PCSRC_CIMM     = 3'b110;  // conditional immediate
  localparam logic [2:0] PCSRC_CSHELLEY = 3'b111;  // conditional indirect

  // Fetch sequencer states; encoding 2'b11 is unused and recovers to FETCH.
  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_WAIT  = 2'b01,
    ST_EXEC  = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC selection for the fetch unit. Purely combinational so it can be
// reused by a pipelined front end.
//   i_pc        current PC
//   i_pc_write  control_unit PCWrite; 0 always selects PC+1
//   i_pc_src    control_unit PCSrc (see cpu_defs PCSRC_*)
//   i_imm       immediate field from IR
//   i_mary      accumulator value
//   i_shelley   second register value
//   i_ra        return-address register
//   i_comp      comparison flag for the conditional encodings
//   o_next_pc   selected next PC
//   o_pc_plus1  PC+1 (also the return address for calls)
module pc_next_mux
  import cpu_defs::*;
#(
  parameter int WIDTH     = 16,
  parameter int IMM_WIDTH = 10
) (
  input  logic [WIDTH-1:0]     i_pc,
  input  logic                 i_pc_write,
  input  logic [2:0]           i_pc_src,
  input  logic [IMM_WIDTH-1:0] i_imm,
  input  logic [WIDTH-1:0]     i_mary,
  input  logic [WIDTH-1:0]     i_shelley,
  input  logic [WIDTH-1:0]     i_ra,
  input  logic                 i_comp,
  output logic [WIDTH-1:0]     o_next_pc,
  output logic [WIDTH-1:0]     o_pc_plus1
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] w_pc_plus1;
  logic [WIDTH-1:0] w_pc_rel;
  logic [WIDTH-1:0] w_page_imm;

  // Adds wrap modulo 2^WIDTH by truncation.
  assign w_pc_plus1 = i_pc + ONE;
  assign w_pc_rel   = i_pc + i_mary;
  // Immediate replaces the low bits; the jump stays within the current page.
  assign w_page_imm = {i_pc[WIDTH-1:IMM_WIDTH], i_imm};

  assign o_pc_plus1 = w_pc_plus1;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case/if can leave it unassigned and infer a latch.
    o_next_pc = w_pc_plus1;
    if (i_pc_write) begin
      case (i_pc_src)
        PCSRC_INC:      o_next_pc = w_pc_plus1;
        PCSRC_SHELLEY:  o_next_pc = i_shelley;
        PCSRC_IMM:      o_next_pc = w_page_imm;
        PCSRC_RA:       o_next_pc = i_ra;
        PCSRC_MARY:     o_next_pc = i_mary;
        PCSRC_REL:      o_next_pc = w_pc_rel;
        PCSRC_CIMM:     o_next_pc = i_comp ? w_page_imm : w_pc_plus1;
        PCSRC_CSHELLEY: o_next_pc = i_comp ? i_shelley  : w_pc_plus1;
        default:        o_next_pc = w_pc_plus1;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Multi-cycle instruction fetch/sequencer stage feeding control_unit.
// Owns PC and IR, runs the instruction-memory request/ready handshake,
// splits IR into OPCODE/flagbit/Imm and applies PCWrite/PCSrc when EXEC ends.
//   CLK, RESET            clock (rising edge), async active-high reset
//   IMemAddr/IMemReq      instruction fetch address (= PC) and request
//   IMemReady/IMemData    memory returns the instruction word
//   OPCODE/flagbit/Imm    IR fields for control_unit and the datapath
//   InstrValid            high while executing (IR fields meaningful)
//   Stall                 datapath holds EXEC
//   PCWrite/PCSrc         next-PC control from control_unit
//   Mary/Shelley/RA/Comp  next-PC operands
//   PCPlus1, PC           PC+1 (return address) and current PC
module instruction_fetch_unit
  import cpu_defs::*;
#(
  parameter int                WIDTH        = 16,
  parameter int                IMM_WIDTH    = 10,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = 16'h0000
) (
  input  logic                 CLK,
  input  logic                 RESET,
  output logic [WIDTH-1:0]     IMemAddr,
  output logic                 IMemReq,
  input  logic                 IMemReady,
  input  logic [WIDTH-1:0]     IMemData,
  output logic [4:0]           OPCODE,
  output logic                 flagbit,
  output logic [IMM_WIDTH-1:0] Imm,
  output logic                 InstrValid,
  input  logic                 Stall,
  input  logic                 PCWrite,
  input  logic [2:0]           PCSrc,
  input  logic [WIDTH-1:0]     Mary,
  input  logic [WIDTH-1:0]     Shelley,
  input  logic [WIDTH-1:0]     RA,
  input  logic                 Comp,
  output logic [WIDTH-1:0]     PCPlus1,
  output logic [WIDTH-1:0]     PC
);

  fetch_state_e     r_state;
  fetch_state_e     w_state_next;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_ir;
  logic             r_imem_req;

  logic             w_req_next;
  logic             w_ir_load;
  logic             w_pc_load;
  logic [WIDTH-1:0] w_next_pc;
  logic [WIDTH-1:0] w_pc_plus1;

  pc_next_mux #(
    .WIDTH     (WIDTH),
    .IMM_WIDTH (IMM_WIDTH)
  ) u_pc_next_mux (
    .i_pc       (r_pc),
    .i_pc_write (PCWrite),
    .i_pc_src   (PCSrc),
    .i_imm      (r_ir[IMM_WIDTH-1:0]),
    .i_mary     (Mary),
    .i_shelley  (Shelley),
    .i_ra       (RA),
    .i_comp     (Comp),
    .o_next_pc  (w_next_pc),
    .o_pc_plus1 (w_pc_plus1)
  );

  // Next-state and register-enable decode.
  always_comb begin
    w_state_next = r_state;
    w_req_next   = r_imem_req;
    w_ir_load    = 1'b0;
    w_pc_load    = 1'b0;
    case (r_state)
      ST_FETCH: begin
        w_req_next   = 1'b1;
        w_state_next = ST_WAIT;
      end
      ST_WAIT: begin
        w_req_next = 1'b1;
        // Ready only counts against an outstanding request.
        if (IMemReady && r_imem_req) begin
          w_ir_load    = 1'b1;
          w_req_next   = 1'b0;
          w_state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_req_next = 1'b0;
        // PCWrite/PCSrc are only consumed on this exit edge.
        if (!Stall) begin
          w_pc_load    = 1'b1;
          w_state_next = ST_FETCH;
        end
      end
      default: begin
        w_req_next   = 1'b0;
        w_state_next = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (RESET) begin
      r_state    <= ST_FETCH;
      r_pc       <= RESET_VECTOR;
      r_ir       <= '0;
      r_imem_req <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_imem_req <= w_req_next;
      if (w_ir_load) r_ir <= IMemData;
      if (w_pc_load) r_pc <= w_next_pc;
    end
  end

  assign IMemAddr   = r_pc;
  assign IMemReq    = r_imem_req;
  assign PC         = r_pc;
  assign PCPlus1    = w_pc_plus1;
  assign InstrValid = (r_state == ST_EXEC);
  assign OPCODE     = r_ir[OP_MSB -: 5];
  assign flagbit    = r_ir[FLAG_BIT];
  assign Imm        = r_ir[IMM_WIDTH-1:0];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed, table-driven bench for instruction_fetch_unit. Each vector is one
// instruction: the memory word, wait states, stall cycles, the control/operand
// values presented on the EXEC exit edge, the fetch address expected and the
// next PC expected. Vectors chain: each exp_next is the following exp_addr.
module tb_instruction_fetch_unit;
  import cpu_defs::*;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [15:0] IMemAddr;
  logic        IMemReq;
  logic        IMemReady;
  logic [15:0] IMemData;
  logic [4:0]  OPCODE;
  logic        flagbit;
  logic [9:0]  Imm;
  logic        InstrValid;
  logic        Stall;
  logic        PCWrite;
  logic [2:0]  PCSrc;
  logic [15:0] Mary;
  logic [15:0] Shelley;
  logic [15:0] RA;
  logic        Comp;
  logic [15:0] PCPlus1;
  logic [15:0] PC;

  instruction_fetch_unit #(
    .WIDTH        (16),
    .IMM_WIDTH    (10),
    .RESET_VECTOR (16'h0000)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .IMemAddr   (IMemAddr),
    .IMemReq    (IMemReq),
    .IMemReady  (IMemReady),
    .IMemData   (IMemData),
    .OPCODE     (OPCODE),
    .flagbit    (flagbit),
    .Imm        (Imm),
    .InstrValid (InstrValid),
    .Stall      (Stall),
    .PCWrite    (PCWrite),
    .PCSrc      (PCSrc),
    .Mary       (Mary),
    .Shelley    (Shelley),
    .RA         (RA),
    .Comp       (Comp),
    .PCPlus1    (PCPlus1),
    .PC         (PC)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge CLK) cyc++;

  typedef struct {
    logic [15:0] instr;
    int          ws;
    int          stall;
    logic        pcw;
    logic [2:0]  src;
    logic [15:0] mary;
    logic [15:0] shelley;
    logic [15:0] ra;
    logic        comp;
    logic [15:0] exp_addr;
    logic [15:0] exp_next;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic summary_and_finish();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  // Waits up to 4 cycles for IMemReq; an expired wait is a failure.
  task automatic wait_req(output int lat);
    bit found;
    found = 1'b0;
    lat   = 0;
    for (int t = 0; t < 4 && !found; t++) begin
      @(negedge CLK);
      if (IMemReq === 1'b1) begin
        found = 1'b1;
        lat   = t;
      end
    end
    if (!found) begin
      checks++;
      failures++;
      $display("FAIL req_timeout: got IMemReq=%0b expected 1", IMemReq);
      summary_and_finish();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] prev_ir;
    logic [15:0] plus1;
    int          lat;
    int          start_cyc;
    int          prev_cost;

    //            instr     ws st pcw src             mary     shelley  ra       comp  addr     next
    vecs[0]  = '{16'h0800, 0, 0, 1'b0, PCSRC_INC,      16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0001};
    vecs[1]  = '{16'h0C00, 0, 0, 1'b1, PCSRC_SHELLEY,  16'h0000, 16'h1C05, 16'h0000, 1'b0, 16'h0001, 16'h1C05};
    vecs[2]  = '{16'h1123, 0, 0, 1'b1, PCSRC_IMM,      16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h1C05, 16'h1D23};
    vecs[3]  = '{16'h1800, 4, 0, 1'b1, PCSRC_RA,       16'h0000, 16'h0000, 16'h0005, 1'b0, 16'h1D23, 16'h0005};
    vecs[4]  = '{16'h0040, 0, 0, 1'b1, PCSRC_CIMM,     16'h0000, 16'h0000, 16'h0000, 1'b1, 16'h0005, 16'h0040};
    vecs[5]  = '{16'h3C40, 0, 0, 1'b1, PCSRC_CIMM,     16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0040, 16'h0041};
    vecs[6]  = '{16'h2000, 0, 0, 1'b1, PCSRC_MARY,     16'h1234, 16'h0000, 16'h0000, 1'b0, 16'h0041, 16'h1234};
    vecs[7]  = '{16'h2801, 1, 0, 1'b1, PCSRC_REL,      16'hFF00, 16'h0000, 16'h0000, 1'b0, 16'h1234, 16'h1134};
    vecs[8]  = '{16'h3000, 0, 0, 1'b1, PCSRC_CSHELLEY, 16'h0000, 16'hABCD, 16'h0000, 1'b0, 16'h1134, 16'h1135};
    vecs[9]  = '{16'h3400, 0, 0, 1'b1, PCSRC_CSHELLEY, 16'h0000, 16'hFFFF, 16'h0000, 1'b1, 16'h1135, 16'hFFFF};
    vecs[10] = '{16'h0123, 0, 0, 1'b0, PCSRC_IMM,      16'h0000, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 16'h0000};
    vecs[11] = '{16'hB7FF, 0, 3, 1'b1, PCSRC_INC,      16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0001};

    RESET     = 1'b1;
    IMemReady = 1'b0;
    IMemData  = 16'h0000;
    Stall     = 1'b0;
    PCWrite   = 1'b0;
    PCSrc     = 3'b000;
    Mary      = 16'h0000;
    Shelley   = 16'h0000;
    RA        = 16'h0000;
    Comp      = 1'b0;

    #1;
    check("rst_req",    {31'b0, IMemReq},    32'd0);
    check("rst_valid",  {31'b0, InstrValid}, 32'd0);
    check("rst_pc",     {16'b0, PC},         32'h0000);
    check("rst_opcode", {27'b0, OPCODE},     32'd0);
    check("rst_flag",   {31'b0, flagbit},    32'd0);
    check("rst_imm",    {22'b0, Imm},        32'd0);

    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    #1;
    check("fetch_req_low", {31'b0, IMemReq}, 32'd0);

    prev_ir   = 16'h0000;
    start_cyc = 0;
    prev_cost = 0;

    for (int i = 0; i < 12; i++) begin
      // Ready with junk data while no request is outstanding must be ignored;
      // Stall outside EXEC must be ignored as well.
      IMemReady = 1'b1;
      IMemData  = 16'hF800;
      Stall     = 1'b1;
      wait_req(lat);
      IMemReady = 1'b0;
      if (i == 0) check("req_rise_latency", lat, 0);
      else        check($sformatf("v%0d_cycles", i - 1), cyc - start_cyc, prev_cost);
      start_cyc = cyc;
      prev_cost = 3 + vecs[i].ws + vecs[i].stall;

      check($sformatf("v%0d_ir_hold_fetch", i), {27'b0, OPCODE}, {27'b0, prev_ir[15:11]});
      check($sformatf("v%0d_addr", i), {16'b0, IMemAddr}, {16'b0, vecs[i].exp_addr});

      for (int w = 0; w < vecs[i].ws; w++) begin
        IMemData = 16'hF800;
        @(negedge CLK);
        check($sformatf("v%0d_ws%0d_req", i, w),    {31'b0, IMemReq},    32'd1);
        check($sformatf("v%0d_ws%0d_addr", i, w),   {16'b0, IMemAddr},   {16'b0, vecs[i].exp_addr});
        check($sformatf("v%0d_ws%0d_valid", i, w),  {31'b0, InstrValid}, 32'd0);
        check($sformatf("v%0d_ws%0d_ir", i, w),     {27'b0, OPCODE},     {27'b0, prev_ir[15:11]});
      end

      IMemReady = 1'b1;
      IMemData  = vecs[i].instr;
      @(negedge CLK);
      IMemReady = 1'b0;
      IMemData  = 16'hF800;
      Stall     = (vecs[i].stall > 0);
      plus1     = vecs[i].exp_addr + 16'h0001;
      check($sformatf("v%0d_valid", i),   {31'b0, InstrValid}, 32'd1);
      check($sformatf("v%0d_req_drop", i), {31'b0, IMemReq},   32'd0);
      check($sformatf("v%0d_opcode", i),  {27'b0, OPCODE},  {27'b0, vecs[i].instr[15:11]});
      check($sformatf("v%0d_flag", i),    {31'b0, flagbit}, {31'b0, vecs[i].instr[10]});
      check($sformatf("v%0d_imm", i),     {22'b0, Imm},     {22'b0, vecs[i].instr[9:0]});
      check($sformatf("v%0d_pc", i),      {16'b0, PC},      {16'b0, vecs[i].exp_addr});
      check($sformatf("v%0d_pcplus1", i), {16'b0, PCPlus1}, {16'b0, plus1});

      // While stalled, PCWrite/PCSrc point at a bogus target; they must not be used.
      for (int s = 0; s < vecs[i].stall; s++) begin
        PCWrite = 1'b1;
        PCSrc   = PCSRC_SHELLEY;
        Shelley = 16'hDEAD;
        @(negedge CLK);
        check($sformatf("v%0d_st%0d_valid", i, s), {31'b0, InstrValid}, 32'd1);
        check($sformatf("v%0d_st%0d_pc", i, s),    {16'b0, PC},         {16'b0, vecs[i].exp_addr});
        check($sformatf("v%0d_st%0d_ir", i, s),    {16'b0, dut.OPCODE, dut.flagbit, dut.Imm}, {16'b0, vecs[i].instr});
      end

      Stall   = 1'b0;
      PCWrite = vecs[i].pcw;
      PCSrc   = vecs[i].src;
      Mary    = vecs[i].mary;
      Shelley = vecs[i].shelley;
      RA      = vecs[i].ra;
      Comp    = vecs[i].comp;
      @(negedge CLK);
      PCWrite = 1'b0;
      PCSrc   = 3'b000;
      check($sformatf("v%0d_next_pc", i),   {16'b0, PC},         {16'b0, vecs[i].exp_next});
      check($sformatf("v%0d_next_addr", i), {16'b0, IMemAddr},   {16'b0, vecs[i].exp_next});
      check($sformatf("v%0d_exit_valid", i), {31'b0, InstrValid}, 32'd0);
      prev_ir = vecs[i].instr;
    end

    // Reset in the middle of a WAIT with a wait state pending.
    IMemReady = 1'b0;
    wait_req(lat);
    check("rw_addr", {16'b0, IMemAddr}, 32'h0001);
    @(negedge CLK);
    check("rw_req_before", {31'b0, IMemReq}, 32'd1);
    #2;
    RESET = 1'b1;
    #1;
    check("rw_req_async", {31'b0, IMemReq},    32'd0);
    check("rw_pc_async",  {16'b0, PC},         32'h0000);
    check("rw_valid",     {31'b0, InstrValid}, 32'd0);
    check("rw_opcode",    {27'b0, OPCODE},     32'd0);

    // Ready while held in reset must not load IR.
    IMemReady = 1'b1;
    IMemData  = 16'hFFFF;
    @(negedge CLK);
    check("rr_opcode", {27'b0, OPCODE},  32'd0);
    check("rr_flag",   {31'b0, flagbit}, 32'd0);
    check("rr_imm",    {22'b0, Imm},     32'd0);
    check("rr_req",    {31'b0, IMemReq}, 32'd0);
    IMemReady = 1'b0;
    RESET     = 1'b0;
    @(negedge CLK);
    check("restart_req",  {31'b0, IMemReq},  32'd1);
    check("restart_addr", {16'b0, IMemAddr}, 32'h0000);

    summary_and_finish();
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Multi-cycle fetch/sequencer stage directly upstream of control_unit.
- Owns the PC and the instruction register (IR), and runs the instruction-memory request/ready handshake.
- Splits IR into OPCODE, flagbit and Imm for control_unit and the datapath.
- Applies control_unit's PCWrite/PCSrc at the end of each execute cycle.

Parameters:
- WIDTH, 16, data/PC/instruction width.
- IMM_WIDTH, 10, immediate field width (IR[IMM_WIDTH-1:0]).
- RESET_VECTOR, 16'h0000, PC value after reset.

Ports:
- CLK  input  1  system clock, rising edge.
- RESET  input  1  asynchronous, active-high reset.
- IMemAddr  output  WIDTH  instruction address; equals PC.
- IMemReq  output  1  fetch request, held until accepted.
- IMemReady  input  1  memory has IMemData valid this cycle.
- IMemData  input  WIDTH  instruction word.
- OPCODE  output  5  IR[15:11], to control_unit.
- flagbit  output  1  IR[10], to control_unit.
- Imm  output  IMM_WIDTH  IR[9:0], zero-extended by consumers.
- InstrValid  output  1  high while in EXEC; IR fields are meaningful.
- Stall  input  1  datapath holds EXEC (multi-cycle data memory).
- PCWrite  input  1  from control_unit.
- PCSrc  input  3  from control_unit.
- Mary  input  WIDTH  accumulator value.
- Shelley  input  WIDTH  second register value.
- RA  input  WIDTH  return-address register.
- Comp  input  1  comparison flag.
- PCPlus1  output  WIDTH  PC+1, RA source for JFNC.
- PC  output  WIDTH  current PC.

Behaviour:
- Reset (async, RESET=1): state=FETCH, PC=RESET_VECTOR, IR=0, IMemReq=0, InstrValid=0. OPCODE/flagbit/Imm are therefore 0.
- FSM states: FETCH, WAIT, EXEC.
- FETCH: registered IMemReq<=1 → WAIT.
- WAIT:
  - IMemReq=1, IMemAddr=PC, both held stable.
  - On IMemReady=1: IR<=IMemData, IMemReq<=0, → EXEC.
  - Otherwise stay in WAIT (unbounded wait states).
- EXEC:
  - InstrValid=1; IR is constant for the whole state.
  - If Stall=1: stay in EXEC; no PC change.
  - If Stall=0: PC<=next_pc, → FETCH.
- next_pc when PCWrite=0: PC+1.
- next_pc when PCWrite=1, by PCSrc:
  - 000: PC+1.
  - 001: Shelley (register-indirect jump/call).
  - 010: {PC[15:10], Imm} (page-absolute immediate).
  - 011: RA (return).
  - 100: Mary.
  - 101: PC+Mary (relative, mod 2^WIDTH).
  - 110: Comp ? {PC[15:10], Imm} : PC+1.
  - 111: Comp ? Shelley : PC+1.
- All adds are modulo 2^WIDTH; PC=16'hFFFF wraps to 16'h0000.
- PCPlus1 is combinational PC+1 and is valid throughout EXEC, so RA captures the return address during JFNC.
- Throughput: minimum 3 cycles per instruction (FETCH, WAIT with immediate ready, EXEC); each memory wait state adds 1 cycle.
- IMemReady while IMemReq=0 is ignored (no IR update).
- IMemReady and RESET together: reset wins; IR stays 0.
- RESET mid-WAIT drops IMemReq immediately (asynchronously); the memory must tolerate an abandoned request.
- Stall outside EXEC is ignored.
- PCWrite/PCSrc are sampled only on the EXEC exit edge.
- No outputs are X after reset; the FSM's unused encoding returns to FETCH.

Decomposition:
- Shared package cpu_defs holds:
  - opcode constants (OP_APUT=5'b00000 … OP_BKRA=5'b10110);
  - PCSrc encodings (PCSRC_INC, PCSRC_SHELLEY, PCSRC_IMM, PCSRC_RA, PCSRC_MARY, PCSRC_REL, PCSRC_CIMM, PCSRC_CSHELLEY);
  - fetch-state enum;
  - field positions (OP_MSB=15, FLAG_BIT=10).
- One natural sub-module: pc_next_mux. It is combinational, computes next_pc from PC, PCWrite, PCSrc and the operands, and is reusable by a later pipelined variant. The FSM, PC and IR registers stay in the top.

Test Plan:
- Reset, then zero-wait memory returning 16'h0800 (SPUT) at addr 0:
  - IMemReq rises 1 cycle after reset release, addr 0.
  - EXEC with OPCODE=5'b00001, flagbit=0.
  - Next fetch at addr 1.
  - 3 cycles per instruction.
- 4 wait states on IMemReady:
  - IMemReq and IMemAddr held stable for all 4 cycles.
  - IR loads only on the ready cycle.
  - InstrValid stays 0 until then.
- JIMM (PCWrite=1, PCSrc=010) at PC=16'h1C05 with Imm=10'h123 → next IMemAddr=16'h1D23.
- JCMP (PCSrc=110) with Imm=10'h040:
  - Comp=1 → next PC=16'h0040 on page 0.
  - Comp=0 → next PC=PC+1.
- Stall held for 3 cycles in EXEC:
  - InstrValid=1 and PC unchanged throughout.
  - PC updates on the cycle Stall falls.
- PC=16'hFFFF with PCWrite=0 → next fetch addr 16'h0000.
- RESET asserted in WAIT → IMemReq=0 and PC=RESET_VECTOR in the same cycle.
